// File: rtl/ff_elastic_buf.sv
// Elastic buffer with valid/ready on both sides. Words leave in arrival order.
// A full buffer refuses new words even when a read happens in the same cycle.
module ff_elastic_buf #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_data,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push;
    logic             pop;

    // DEPTH need not be a power of two, so pointers wrap explicitly.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign in_ready  = !rst && (count_q < DEPTH_C);
    assign out_valid = (count_q != '0);
    assign out_data  = mem_q[rd_ptr_q];
    assign count     = count_q;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push) begin
                mem_q[wr_ptr_q] <= in_data;
            end
        end
    end

endmodule

// File: tb/tb_ff_elastic_buf.sv
// Bench for ff_elastic_buf: directed scenarios followed by random traffic,
// checked each cycle against a queue-based occupancy model.
module tb_ff_elastic_buf;

    localparam int WIDTH = 4;
    localparam int DEPTH = 3;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [CNT_W-1:0] count;

    int errors = 0;
    int checks = 0;
    bit armed  = 1'b0;
    bit fresh  = 1'b1;
    logic [WIDTH-1:0] sb_q[$];

    ff_elastic_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs are stable from posedge+1 to the next posedge, so the negedge sees
    // exactly what the coming edge will act on.
    always @(negedge clk) begin
        if (armed) begin
            int  sz;
            bit  exp_valid;
            bit  exp_ready;
            sz        = sb_q.size();
            exp_valid = (sz != 0);
            exp_ready = !rst && (sz < DEPTH);
            chk("count", 32'(count), 32'(sz));
            chk("out_valid", 32'(out_valid), 32'(exp_valid));
            chk("in_ready", 32'(in_ready), 32'(exp_ready));
            if (exp_valid) begin
                chk("out_data", 32'(out_data), 32'(sb_q[0]));
            end else if (fresh) begin
                chk("out_data_zero", 32'(out_data), 32'h0);
            end
            if (rst) begin
                sb_q.delete();
                fresh = 1'b1;
            end else begin
                if (exp_valid && out_ready) begin
                    $display("pop  data=%h count=%0d", sb_q[0], sz);
                    void'(sb_q.pop_front());
                end
                if (in_valid && exp_ready) begin
                    $display("push data=%h count=%0d", in_data, sz);
                    sb_q.push_back(in_data);
                    fresh = 1'b0;
                end
            end
        end
    end

    task automatic cyc(input logic r, input logic v, input logic [WIDTH-1:0] d, input logic ordy);
        rst       = r;
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [WIDTH-1:0] seq [6];
        seq[0] = 4'hA; seq[1] = 4'hB; seq[2] = 4'hC;
        seq[3] = 4'hD; seq[4] = 4'hE; seq[5] = 4'hF;

        rst = 1'b1; in_valid = 1'b1; in_data = 4'hF; out_ready = 1'b0;
        @(posedge clk);
        #1;
        armed = 1'b1;

        // Reset held with a word offered upstream
        cyc(1'b1, 1'b1, 4'hF, 1'b0);
        cyc(1'b1, 1'b1, 4'hF, 1'b0);

        // Fill, then offer a fourth word that must be refused
        cyc(1'b0, 1'b1, 4'h1, 1'b0);
        cyc(1'b0, 1'b1, 4'h2, 1'b0);
        cyc(1'b0, 1'b1, 4'h3, 1'b0);
        cyc(1'b0, 1'b1, 4'h4, 1'b0);
        cyc(1'b0, 1'b1, 4'h4, 1'b0);

        // Drain
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 4'h0, 1'b1);

        // Simultaneous push/pop at count 1, crossing the pointer wrap
        cyc(1'b0, 1'b1, 4'h5, 1'b0);
        for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, seq[i], 1'b1);
        for (int i = 0; i < 2; i++) cyc(1'b0, 1'b0, 4'h0, 1'b1);

        // Full plus pop: first cycle refuses, second accepts
        cyc(1'b0, 1'b1, 4'h1, 1'b0);
        cyc(1'b0, 1'b1, 4'h2, 1'b0);
        cyc(1'b0, 1'b1, 4'h3, 1'b0);
        cyc(1'b0, 1'b1, 4'h5, 1'b1);
        cyc(1'b0, 1'b1, 4'h5, 1'b1);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 4'h0, 1'b1);

        // Reset mid-stream discards contents
        cyc(1'b0, 1'b1, 4'h7, 1'b0);
        cyc(1'b0, 1'b1, 4'h8, 1'b0);
        cyc(1'b1, 1'b0, 4'h0, 1'b0);
        cyc(1'b0, 1'b1, 4'h9, 1'b0);
        for (int i = 0; i < 2; i++) cyc(1'b0, 1'b0, 4'h0, 1'b1);

        // Random traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 59) == 0),
                ($urandom_range(0, 99) < 60),
                WIDTH'($urandom),
                ($urandom_range(0, 99) < 50));
        end
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 4'h0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
